// File: rtl/frogger_pkg.sv
// frogger_pkg: turn-scheduler state type, home-row geometry and slot lookup
package frogger_pkg;
  typedef enum logic [2:0] {IDLE, SPAWN, PLAY, DYING, HOMED, HALT} state_t;
  localparam int NUM_FROGS = 3;
  localparam logic [10:0] HOME_Y = 11'd40;
  localparam logic [2:0][10:0] SLOT_X = {11'd480, 11'd280, 11'd120};
  function automatic logic [1:0] slot_index(input logic [10:0] x);
    return x == SLOT_X[0] ? 2'd0 : x == SLOT_X[1] ? 2'd1 : x == SLOT_X[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/frog_turn_scheduler_if.sv
// frog_turn_scheduler_if: datapath/game-FSM side signals of the turn scheduler
interface frog_turn_scheduler_if;
  logic game_active;
  logic [10:0] frog_x;
  logic [10:0] frog_y;
  logic hazard_hit;
  logic [1:0] active_frog;
  logic spawn_pulse;
  logic freeze;
  logic [2:0] home_mask;
  logic dead_frog;
  logic [7:0] time_left;
  logic all_home;
  modport master(
    output game_active, frog_x, frog_y, hazard_hit,
    input active_frog, spawn_pulse, freeze, home_mask, dead_frog, time_left, all_home
  );
  modport slave(
    input game_active, frog_x, frog_y, hazard_hit,
    output active_frog, spawn_pulse, freeze, home_mask, dead_frog, time_left, all_home
  );
endinterface

// File: rtl/frog_turn_scheduler_life_timer.sv
// life_timer: per-life frame counter and seconds countdown saturating at zero
module life_timer #(
  parameter int TIME_SECS = 30,
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic       frame_clk,
  input  logic       game_restart,
  input  logic       load,
  input  logic       run,
  output logic [7:0] time_left,
  output logic       timeout
);
  localparam int CW = $clog2(FRAMES_PER_SEC + 1);
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] time_left_q, time_left_d;
  logic wrap;
  always_comb begin
    wrap = frame_cnt_q == CW'(FRAMES_PER_SEC - 1);
    frame_cnt_d = load || (run && wrap) ? '0 : run ? frame_cnt_q + 1'b1 : frame_cnt_q;
    time_left_d = load ? 8'(TIME_SECS) : run && wrap && time_left_q != 8'd0 ? time_left_q - 8'd1 : time_left_q;
  end
  always_ff @(posedge frame_clk or posedge game_restart) begin
    if (game_restart) begin
      frame_cnt_q <= '0;
      time_left_q <= 8'(TIME_SECS);
    end else begin
      frame_cnt_q <= frame_cnt_d;
      time_left_q <= time_left_d;
    end
  end
  // the wrap that finds the clock already at zero ends the life
  assign timeout = run && wrap && time_left_q == 8'd0;
  assign time_left = time_left_q;
endmodule

// File: rtl/frog_turn_scheduler.sv
// frog_turn_scheduler: sequences the three frogs through spawn, play, death and homing
module frog_turn_scheduler
  import frogger_pkg::*;
#(
  parameter int TIME_SECS = 30,
  parameter int FRAMES_PER_SEC = 60,
  parameter int DEATH_FRAMES = 60
) (
  input logic frame_clk,
  input logic game_restart,
  frog_turn_scheduler_if.slave bus
);
  localparam int DW = $clog2(DEATH_FRAMES + 1);
  localparam logic [2:0] FULL = 3'((1 << NUM_FROGS) - 1);
  state_t state_q, state_d;
  logic [1:0] active_frog_q, active_frog_d;
  logic [2:0] home_mask_q, home_mask_d, slot_bit, new_mask;
  logic [DW-1:0] death_cnt_q, death_cnt_d;
  logic at_home, home_ok, timeout;
  life_timer #(.TIME_SECS(TIME_SECS), .FRAMES_PER_SEC(FRAMES_PER_SEC)) u_timer (
    .frame_clk(frame_clk),
    .game_restart(game_restart),
    .load(state_d == SPAWN),
    .run(state_q == PLAY),
    .time_left(bus.time_left),
    .timeout(timeout)
  );
  always_comb begin
    slot_bit = 3'b001 << slot_index(bus.frog_x);
    new_mask = home_mask_q | slot_bit;
    at_home = bus.frog_y == HOME_Y;
    home_ok = at_home && slot_bit != 3'b000 && (home_mask_q & slot_bit) == 3'b000;
    state_d = state_q;
    active_frog_d = active_frog_q;
    home_mask_d = home_mask_q;
    death_cnt_d = death_cnt_q;
    case (state_q)
      IDLE:  state_d = SPAWN;
      SPAWN: state_d = PLAY;
      PLAY: begin
        if (!bus.game_active) state_d = HALT;
        else if (bus.hazard_hit || (at_home && !home_ok)) begin
          state_d = DYING;
          death_cnt_d = '0;
        end else if (home_ok) begin
          state_d = HOMED;
          home_mask_d = new_mask;
          active_frog_d = new_mask == FULL ? 2'd3 : active_frog_q + 2'd1;
        end else if (timeout) begin
          state_d = DYING;
          death_cnt_d = '0;
        end
      end
      DYING: begin
        if (!bus.game_active) state_d = HALT;
        else if (death_cnt_q == DW'(DEATH_FRAMES - 1)) state_d = SPAWN;
        else death_cnt_d = death_cnt_q + 1'b1;
      end
      HOMED:   state_d = home_mask_q == FULL ? HALT : SPAWN;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge frame_clk or posedge game_restart) begin
    if (game_restart) begin
      state_q <= IDLE;
      active_frog_q <= 2'd0;
      home_mask_q <= 3'b000;
      death_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      active_frog_q <= active_frog_d;
      home_mask_q <= home_mask_d;
      death_cnt_q <= death_cnt_d;
    end
  end
  // pulses decode from registered state so an async reset clears them at once
  assign bus.spawn_pulse = state_q == SPAWN;
  assign bus.dead_frog = state_q == DYING && death_cnt_q == '0;
  assign bus.freeze = state_q != PLAY;
  assign bus.active_frog = active_frog_q;
  assign bus.home_mask = home_mask_q;
  assign bus.all_home = home_mask_q == FULL;
endmodule

// File: tb/tb_frog_turn_scheduler.sv
// tb_frog_turn_scheduler: directed checks of turn sequencing, timeout, homing and reset
module tb_frog_turn_scheduler;
  logic frame_clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int dead_seen = 0;
  int dead_before;
  logic saw_255;
  frog_turn_scheduler_if bus();
  frog_turn_scheduler dut (.frame_clk(frame_clk), .game_restart(rst), .bus(bus));
  always #5 frame_clk = ~frame_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(negedge frame_clk);
      if (bus.dead_frog) dead_seen++;
    end
  endtask
  task automatic drive(input logic [10:0] x, input logic [10:0] y, input logic hit);
    bus.frog_x = x;
    bus.frog_y = y;
    bus.hazard_hit = hit;
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, "_active"}, bus.active_frog, 0);
    chk({tag, "_spawn"}, bus.spawn_pulse, 0);
    chk({tag, "_freeze"}, bus.freeze, 1);
    chk({tag, "_mask"}, bus.home_mask, 0);
    chk({tag, "_dead"}, bus.dead_frog, 0);
    chk({tag, "_time"}, bus.time_left, 30);
    chk({tag, "_allhome"}, bus.all_home, 0);
  endtask
  initial begin
    rst = 1'b1;
    bus.game_active = 1'b1;
    drive(0, 0, 0);
    step(2);
    reset_checks("rst");
    rst = 1'b0;
    chk("idle_spawn", bus.spawn_pulse, 0);
    step(1);
    chk("spawn_pulse", bus.spawn_pulse, 1);
    chk("spawn_active", bus.active_frog, 0);
    chk("spawn_time", bus.time_left, 30);
    chk("spawn_freeze", bus.freeze, 1);
    step(1);
    chk("play_spawn", bus.spawn_pulse, 0);
    chk("play_freeze", bus.freeze, 0);
    drive(280, 40, 0);
    step(1);
    chk("home1_mask", bus.home_mask, 3'b010);
    chk("home1_active", bus.active_frog, 1);
    chk("home1_spawn", bus.spawn_pulse, 0);
    chk("home1_dead", bus.dead_frog, 0);
    drive(0, 0, 0);
    step(1);
    chk("home1_respawn", bus.spawn_pulse, 1);
    chk("home1_resp_active", bus.active_frog, 1);
    step(1);
    drive(280, 40, 0);
    step(1);
    chk("taken_dead", bus.dead_frog, 1);
    chk("taken_freeze", bus.freeze, 1);
    chk("taken_mask", bus.home_mask, 3'b010);
    drive(0, 0, 0);
    step(59);
    chk("dying_freeze", bus.freeze, 1);
    chk("dying_spawn", bus.spawn_pulse, 0);
    step(1);
    chk("taken_respawn", bus.spawn_pulse, 1);
    chk("taken_active", bus.active_frog, 1);
    chk("taken_mask2", bus.home_mask, 3'b010);
    chk("taken_pulses", dead_seen, 1);
    step(1);
    chk("to_time_start", bus.time_left, 30);
    saw_255 = 1'b0;
    for (int i = 0; i < 1859; i++) begin
      step(1);
      if (bus.time_left == 8'd255) saw_255 = 1'b1;
      if (i == 1798) chk("to_time_one", bus.time_left, 1);
      if (i == 1799) chk("to_time_zero", bus.time_left, 0);
    end
    chk("to_still_play", bus.freeze, 0);
    chk("to_no_dead_yet", bus.dead_frog, 0);
    step(1);
    chk("to_dead", bus.dead_frog, 1);
    chk("to_time_sat", bus.time_left, 0);
    chk("to_no_wrap", saw_255, 0);
    chk("to_pulses", dead_seen, 2);
    step(60);
    chk("to_respawn", bus.spawn_pulse, 1);
    chk("to_reload", bus.time_left, 30);
    chk("to_active", bus.active_frog, 1);
    step(1);
    drive(120, 40, 1);
    step(1);
    chk("hit_home_dead", bus.dead_frog, 1);
    chk("hit_home_mask", bus.home_mask, 3'b010);
    drive(0, 0, 0);
    step(61);
    chk("hit_play", bus.freeze, 0);
    step(1859);
    drive(120, 40, 0);
    step(1);
    chk("tohome_mask", bus.home_mask, 3'b011);
    chk("tohome_active", bus.active_frog, 2);
    chk("tohome_dead", bus.dead_frog, 0);
    drive(0, 0, 0);
    step(2);
    drive(480, 40, 0);
    step(1);
    chk("all_mask", bus.home_mask, 3'b111);
    chk("all_active", bus.active_frog, 3);
    chk("all_home", bus.all_home, 1);
    chk("all_freeze", bus.freeze, 1);
    drive(0, 0, 0);
    step(3);
    chk("halt_freeze", bus.freeze, 1);
    chk("halt_spawn", bus.spawn_pulse, 0);
    chk("halt_active", bus.active_frog, 3);
    chk("halt_allhome", bus.all_home, 1);
    chk("halt_pulses", dead_seen, 3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);
    drive(120, 40, 0);
    step(1);
    chk("fresh_mask", bus.home_mask, 3'b001);
    drive(0, 0, 0);
    step(72);
    chk("fresh_time", bus.time_left, 29);
    drive(0, 0, 1);
    step(1);
    chk("fresh_dead", bus.dead_frog, 1);
    drive(0, 0, 0);
    step(5);
    chk("fresh_dying_freeze", bus.freeze, 1);
    dead_before = dead_seen;
    #2 rst = 1'b1;
    #1 reset_checks("mid_dying");
    step(3);
    chk("mid_dying_nopulse", dead_seen, dead_before);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frog_turn_scheduler.md
Name: frog_turn_scheduler

Overview:
Sequences the three player frogs through their turns. It selects which frog is live and issues spawn and freeze controls to the frog position modules. It times each life and arbitrates the three home slots (Y=40; X=120/280/480). It also produces the one-cycle dead_frog pulse and the all_home flag consumed by the game-level win/lose FSM, and it sits between the frog/collision datapath and that FSM.

Parameters:
TIME_SECS, 30, seconds allowed per life; reloaded on every spawn
FRAMES_PER_SEC, 60, frame_clk ticks per second of game time
DEATH_FRAMES, 60, frames frozen after a death before respawn
HOME_Y, 40, Y coordinate of the home row

Ports:
frame_clk  in  1  frame-rate clock; all state updates on its rising edge
game_restart  in  1  asynchronous, active-high reset
game_active  in  1  high while the game FSM is neither WIN nor LOSE
frog_x  in  11  X position of the currently active frog
frog_y  in  11  Y position of the currently active frog
hazard_hit  in  1  collision detector: active frog touches car/water this frame
active_frog  out  2  live frog index 0..2; 3 = none (all home)
spawn_pulse  out  1  one-cycle: selected frog module reloads its start position
freeze  out  1  high = frog movement inputs ignored
home_mask  out  3  bit i set = home slot i occupied
dead_frog  out  1  one-cycle pulse per life lost
time_left  out  8  seconds remaining for the current life
all_home  out  1  high once home_mask == 3'b111

Behaviour:
- Reset values (async, game_restart=1):
  - state=IDLE, active_frog=0, spawn_pulse=0, freeze=1, home_mask=0
  - dead_frog=0, time_left=TIME_SECS, all_home=0
  - frame counter=0, death counter=0
- States: IDLE, SPAWN, PLAY, DYING, HOMED, HALT.
- IDLE -> SPAWN on the next edge after reset release.
- SPAWN (1 cycle):
  - spawn_pulse=1, freeze=1
  - time_left=TIME_SECS, frame counter=0
  - -> PLAY
- PLAY:
  - freeze=0; frame counter increments each cycle.
  - At FRAMES_PER_SEC-1 the counter wraps to 0 and time_left decrements.
  - Evaluation order per cycle, first match wins:
    1. game_active=0 -> HALT.
    2. hazard_hit=1 -> DYING.
    3. frog_y==HOME_Y and frog_x matches slot i with home_mask[i]=0 -> HOMED with slot i.
    4. frog_y==HOME_Y with any other frog_x, or with slot i already occupied -> DYING.
    5. time_left==0 and counter wrap -> DYING (timeout).
  - A hit and a home arrival in the same cycle resolve to death.
  - A home arrival in the timeout cycle resolves to HOMED.
- DYING:
  - On entry: dead_frog=1 for exactly one cycle; freeze=1.
  - Death counter runs 0..DEATH_FRAMES-1, then -> SPAWN with the same active_frog.
  - game_active falling during DYING -> HALT; the counter is abandoned.
- HOMED (1 cycle):
  - Set home_mask[i]; freeze=1.
  - If the new mask is 3'b111: active_frog=3, all_home=1, -> HALT.
  - Otherwise active_frog increments and the next state is SPAWN.
  - Slot claiming is first-come: a slot claimed earlier is never cleared except by reset.
- HALT:
  - Terminal until reset. freeze=1, all counters stop, outputs hold, no pulses.
- Width and edge rules:
  - time_left is an unsigned 8-bit value and saturates at 0 (never wraps to 255).
  - active_frog never exceeds 3.
  - spawn_pulse and dead_frog are never high in the same cycle.
- Reset asserted mid-DYING or mid-PLAY returns every output to its reset value immediately (async); no dead_frog pulse is emitted.

Decomposition:
- Shared package frogger_pkg holds:
  - the state enum type
  - constants HOME_Y, SLOT_X[0..2] = 120/280/480, NUM_FROGS=3
  - a function slot_index(x) returning 0..2, or 3 for no slot
  - The existing game FSM also uses the slot constants from this package.
- One sub-module, life_timer, covers the frame counter, time_left countdown with saturation, and a timeout strobe.
  - Inputs: frame_clk, game_restart, load, run.
  - Outputs: time_left, timeout.

Test Plan:
- Reset, release, idle 2 frames -> spawn_pulse high exactly in cycle 2; active_frog=0; time_left=30; freeze falls the following cycle.
- PLAY, then frog_x=280, frog_y=40 -> home_mask=3'b010, active_frog=1, spawn_pulse one cycle later; dead_frog stays 0.
- Slot 1 taken, frog 1 arrives at X=280 Y=40 -> dead_frog pulse; freeze held 60 frames; respawn with active_frog=1 and home_mask unchanged.
- No input for 30*60 frames -> time_left reaches 0, dead_frog pulses on the wrap cycle; time_left never reads 255.
- hazard_hit and a valid home arrival in the same cycle -> death wins, home_mask unchanged. Separately, home arrival at the timeout cycle -> HOMED.
- Homes at 120, 280, 480 in sequence -> all_home=1, active_frog=3, freeze=1. Then game_restart mid-DYING on a fresh run -> all outputs return to reset values with no dead_frog pulse.
